// File: rtl/dense_layer_seq.sv
// -----------------------------------------------------------------------------
// dense_layer_seq
//
// Sequential fully-connected layer with ReLU:
//   out[j] = relu( sum_i in[i] * w[i*D2 + j] + b[j] )   for j = 0..D2-1
// All arithmetic wraps modulo 2^W. Each product keeps only its low W bits, and
// the accumulator is W bits wide.
//
// The D1 input elements are buffered first. Each output j is then computed with
// one weight read per cycle from an external synchronous memory (1-cycle read
// latency). A bias read follows, and the ReLU result is presented on a
// valid/ready output port.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   input element valid
//   in_data    input element (signed, W bits), indices 0..D1-1 in arrival order
//   in_ready   block accepts an input element (IDLE / LOAD)
//   w_rd_en    weight memory read strobe
//   w_addr     weight address i*D2+j
//   w_rdata    weight data, valid one cycle after w_rd_en
//   b_rd_en    bias memory read strobe
//   b_addr     bias address j
//   b_rdata    bias data, valid one cycle after b_rd_en
//   out_valid  output element valid
//   out_ready  consumer accepts the output element
//   out_data   ReLU output element
//   out_idx    index j of out_data
//   done       one-cycle pulse after the last output handshake
// -----------------------------------------------------------------------------
module dense_layer_seq #(
  parameter int D1 = 4,
  parameter int D2 = 4,
  parameter int W  = 8
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        in_valid,
  input  logic [W-1:0]                                in_data,
  output logic                                        in_ready,
  output logic                                        w_rd_en,
  output logic [((D1*D2 > 1) ? $clog2(D1*D2) : 1)-1:0] w_addr,
  input  logic [W-1:0]                                w_rdata,
  output logic                                        b_rd_en,
  output logic [((D2 > 1) ? $clog2(D2) : 1)-1:0]      b_addr,
  input  logic [W-1:0]                                b_rdata,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [W-1:0]                                out_data,
  output logic [((D2 > 1) ? $clog2(D2) : 1)-1:0]      out_idx,
  output logic                                        done
);

  localparam int WAW = (D1*D2 > 1) ? $clog2(D1*D2) : 1;
  localparam int JW  = (D2 > 1) ? $clog2(D2) : 1;
  localparam int CW  = (D1 > 1) ? $clog2(D1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_BIAS,
    S_OUT
  } state_t;

  state_t                r_state;
  state_t                w_next;

  // r_cnt counts accepted elements in IDLE/LOAD and issued weight reads in MAC
  logic [CW-1:0]         r_cnt;
  logic [JW-1:0]         r_j;
  logic signed [W-1:0]   r_buf [D1];
  logic signed [W-1:0]   r_acc;
  logic                  r_mac_vld_p1;
  logic [CW-1:0]         r_mac_idx_p1;
  logic                  r_bias_ph;
  logic [W-1:0]          r_out_data;
  logic [JW-1:0]         r_out_idx;
  logic                  r_done;

  logic                  w_accept;
  logic                  w_out_hs;
  logic                  w_last_el;
  logic                  w_last_j;
  logic signed [W-1:0]   w_sum;

  // Multiply-accumulate, keeping only the low W bits of the product.
  function automatic logic signed [W-1:0] f_mac(input logic signed [W-1:0] acc,
                                                input logic signed [W-1:0] a,
                                                input logic signed [W-1:0] b);
    logic signed [2*W-1:0] prod;
    prod = a * b;
    return acc + prod[W-1:0];
  endfunction

  // ReLU on a W-bit two's-complement value.
  function automatic logic [W-1:0] f_relu(input logic signed [W-1:0] x);
    return x[W-1] ? '0 : x;
  endfunction

  assign w_accept  = in_valid && in_ready;
  assign w_out_hs  = out_valid && out_ready;
  assign w_last_el = (r_cnt == CW'(D1 - 1));
  assign w_last_j  = (r_j == JW'(D2 - 1));
  assign w_sum     = r_acc + signed'(b_rdata);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      // In IDLE the counter is 0, so w_last_el is true only when D1 == 1.
      S_IDLE: if (w_accept) w_next = w_last_el ? S_MAC : S_LOAD;
      S_LOAD: if (w_accept && w_last_el) w_next = S_MAC;
      S_MAC:  if (w_last_el) w_next = S_BIAS;
      // Phase 0 issues the bias read; phase 1 sees the bias data.
      S_BIAS: if (r_bias_ph) w_next = S_OUT;
      S_OUT:  if (w_out_hs) w_next = w_last_j ? S_IDLE : S_MAC;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (r_state == S_IDLE) || (r_state == S_LOAD);
    w_rd_en   = (r_state == S_MAC);
    b_rd_en   = (r_state == S_BIAS) && !r_bias_ph;
    out_valid = (r_state == S_OUT);
    w_addr    = '0;
    if (r_state == S_MAC) begin
      w_addr = WAW'(32'(r_cnt) * D2 + 32'(r_j));
    end
    b_addr    = r_j;
    out_data  = r_out_data;
    out_idx   = r_out_idx;
    done      = r_done;
  end

  // Input buffer; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[r_cnt] <= signed'(in_data);
    end
  end

  // Counters, accumulator and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_j          <= '0;
      r_acc        <= '0;
      r_mac_vld_p1 <= 1'b0;
      r_mac_idx_p1 <= '0;
      r_bias_ph    <= 1'b0;
      r_out_data   <= '0;
      r_out_idx    <= '0;
      r_done       <= 1'b0;
    end else begin
      // p0 -> p1: weight read issued; the data returns on the next cycle
      r_mac_vld_p1 <= w_rd_en;
      r_mac_idx_p1 <= r_cnt;
      r_done       <= w_out_hs && w_last_j;

      if (w_accept || (r_state == S_MAC)) begin
        r_cnt <= w_last_el ? '0 : r_cnt + 1'b1;
      end

      if (r_state == S_BIAS) begin
        r_bias_ph <= ~r_bias_ph;
      end

      // No product is pending on the first read of an output, so that cycle
      // clears the accumulator.
      if ((r_state == S_MAC) && (r_cnt == '0)) begin
        r_acc <= '0;
      end else if (r_mac_vld_p1) begin
        r_acc <= f_mac(r_acc, r_buf[r_mac_idx_p1], signed'(w_rdata));
      end else if ((r_state == S_BIAS) && r_bias_ph) begin
        r_acc <= w_sum;
      end

      // p1 -> out: the bias is available, so register the ReLU result
      if ((r_state == S_BIAS) && r_bias_ph) begin
        r_out_data <= f_relu(w_sum);
        r_out_idx  <= r_j;
      end

      if (w_out_hs) begin
        r_j <= w_last_j ? '0 : r_j + 1'b1;
      end
    end
  end

endmodule
